// File: rtl/md_ctrl_pkg.sv
// rtl/md_ctrl_pkg.sv - shared md_op codes, FSM encoding and cycle defaults for the mult/div unit
package md_ctrl_pkg;

    // Decoder-visible operation codes; 9-15 decode as no operation.
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    // Latched description of the operation in flight.
    typedef struct packed {
        logic is_signed;
        logic is_div;
    } md_kind_t;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int CNT_W           = 4;

    // True for the four ops that occupy the unit for several cycles.
    function automatic logic is_arith_op(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// rtl/md_ctrl_if.sv - pipeline-to-mult/div unit bundle with pipeline and unit views
interface md_ctrl_if;
    logic [3:0]  md_op;
    logic        start;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        md_use_D;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;
    logic        md_stall;

    // Pipeline side issues ops and consumes results/stall.
    modport master (
        output md_op, start, rs, rt, md_use_D,
        input  busy, hi, lo, md_out, md_stall
    );

    // Mult/div unit side.
    modport slave (
        input  md_op, start, rs, rt, md_use_D,
        output busy, hi, lo, md_out, md_stall
    );
endinterface

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational product, quotient and remainder from latched operands
module md_arith
    import md_ctrl_pkg::*;
(
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  md_kind_t    kind,
    output logic [63:0] product,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;

    // Low 64 bits of the product of extended operands equal the signed or unsigned 32x32 product.
    always_comb begin
        ext_a   = kind.is_signed ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
        ext_b   = kind.is_signed ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
        product = ext_a * ext_b;
    end

    // Signed divide via magnitudes: quotient truncates toward zero, remainder takes the dividend sign.
    // The divider only sees operands for div ops; a zero divisor yields zero (the caller skips the write).
    always_comb begin
        neg_a = kind.is_signed & op_a[31];
        neg_b = kind.is_signed & op_b[31];
        mag_a = '0;
        mag_b = '0;
        if (kind.is_div) begin
            mag_a = neg_a ? (~op_a + 32'd1) : op_a;
            mag_b = neg_b ? (~op_b + 32'd1) : op_b;
        end
        uq = '0;
        ur = '0;
        if (mag_b != 32'd0) begin
            uq = mag_a / mag_b;
            ur = mag_a % mag_b;
        end
        quotient  = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
        remainder = neg_a ? (~ur + 32'd1) : ur;
    end

endmodule

// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - multi-cycle mult/div sequencer owning architectural HI/LO
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic      clk,
    input  logic      reset,
    md_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    md_kind_t         kind_q, kind_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [63:0]      product;
    logic [31:0]      quotient;
    logic [31:0]      remainder;

    md_arith u_arith (
        .op_a      (a_q),
        .op_b      (b_q),
        .kind      (kind_q),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // Next-state: accept ops only when idle; write HI/LO on the final busy cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        kind_d  = kind_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && is_arith_op(bus.md_op)) begin
                    a_d              = bus.rs;
                    b_d              = bus.rt;
                    kind_d.is_signed = (bus.md_op == MD_MULT) || (bus.md_op == MD_DIV);
                    kind_d.is_div    = (bus.md_op == MD_DIV)  || (bus.md_op == MD_DIVU);
                    if (kind_d.is_div) begin
                        state_d = ST_DIV;
                        cnt_d   = DIV_LAST;
                    end else begin
                        state_d = ST_MULT;
                        cnt_d   = MULT_LAST;
                    end
                end else if (bus.md_op == MD_MTHI) begin
                    hi_d = bus.rs;
                end else if (bus.md_op == MD_MTLO) begin
                    lo_d = bus.rs;
                end
            end
            ST_MULT: begin
                if (cnt_q == '0) begin
                    hi_d    = product[63:32];
                    lo_d    = product[31:0];
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DIV: begin
                if (cnt_q == '0) begin
                    // Divide by zero still burns the full latency but leaves HI/LO alone.
                    if (b_q != 32'd0) begin
                        hi_d = remainder;
                        lo_d = quotient;
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset aborts any op in flight and clears HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            kind_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            kind_q  <= kind_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Read port and D-stage stall.
    always_comb begin
        bus.busy     = (state_q != ST_IDLE);
        bus.hi       = hi_q;
        bus.lo       = lo_q;
        bus.md_stall = bus.md_use_D & (bus.start | bus.busy);
        case (bus.md_op)
            MD_MFHI: bus.md_out = hi_q;
            MD_MFLO: bus.md_out = lo_q;
            default: bus.md_out = 32'd0;
        endcase
    end

endmodule
